// File: rtl/cpu_bus_pkg.sv
// Shared types and address constants for the CPU-side bus blocks.
// The OAM DMA engine copies one 256-byte page into the sprite-data port.
package cpu_bus_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  byte_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam addr_t OAM_DMA_TRIG = 16'h4014;
    localparam addr_t OAM_DATA     = 16'h2004;
    localparam int    XFER_LEN     = 256;

endpackage

// File: rtl/cpu_oam_dma.sv
// OAM DMA bus master: passes the 6502 bus through while idle, otherwise
// stalls the core and copies page src_page to the sprite-data port.
module cpu_oam_dma
    import cpu_bus_pkg::*;
#(
    parameter addr_t TRIG_ADDR = OAM_DMA_TRIG,
    parameter addr_t DST_ADDR  = OAM_DATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    input  logic [7:0]  mem_di,
    output logic        dma_busy
);

    localparam byte_t LAST_IDX = byte_t'(XFER_LEN - 1);

    dma_state_t state;
    byte_t      idx;
    byte_t      src_page;
    byte_t      data_q;
    logic       cyc_par;
    logic       rdy_q;
    logic       busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            src_page <= '0;
            data_q   <= '0;
            cyc_par  <= 1'b0;
            rdy_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            cyc_par <= ~cyc_par;
            case (state)
                IDLE: begin
                    if (cpu_we && cpu_ab == TRIG_ADDR) begin
                        src_page <= cpu_do;
                        idx      <= '0;
                        state    <= HALT;
                        rdy_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                // Reads must land on even cycles; an odd HALT is already aligned.
                HALT:  state <= cyc_par ? READ : ALIGN;
                ALIGN: state <= READ;
                READ: begin
                    data_q <= mem_di;
                    state  <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        state  <= IDLE;
                        rdy_q  <= 1'b1;
                        busy_q <= 1'b0;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= READ;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rdy_q  <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux: CPU pass-through unless the engine owns a READ/WRITE slot.
    always_comb begin
        mem_ab = cpu_ab;
        mem_do = cpu_do;
        mem_we = cpu_we;
        case (state)
            IDLE: ;
            READ: begin
                mem_ab = {src_page, idx};
                mem_we = 1'b0;
            end
            WRITE: begin
                mem_ab = DST_ADDR;
                mem_do = data_q;
                mem_we = 1'b1;
            end
            default: mem_we = 1'b0;
        endcase
    end

    assign cpu_di   = mem_di;
    assign cpu_rdy  = rdy_q;
    assign dma_busy = busy_q;

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Directed bench for cpu_oam_dma with a 64K memory model and a sprite-port
// write monitor; expected data comes from the bench's own page contents.
module tb_cpu_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di;
    logic        dma_busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  mem [0:65535];
    logic [7:0]  wr_q [$];
    logic [15:0] rd_q [$];
    logic        rdpar_q [$];
    logic        tbpar = 1'b0;

    cpu_oam_dma dut (
        .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do),
        .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy), .mem_ab(mem_ab),
        .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di), .dma_busy(dma_busy)
    );

    always #5 clk = ~clk;

    assign mem_di = mem[mem_ab];

    // Independent cycle parity: 0 in the first cycle after a reset edge.
    always @(posedge clk) tbpar = reset ? 1'b0 : ~tbpar;

    always @(negedge clk) begin
        if (mem_we && mem_ab == 16'h2004) wr_q.push_back(mem_do);
        else if (mem_we) mem[mem_ab] = mem_do;
        if (dma_busy && !mem_we && mem_ab != cpu_ab) begin
            rd_q.push_back(mem_ab);
            rdpar_q.push_back(tbpar);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_ab = 16'h0000; cpu_do = 8'h00; cpu_we = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total++; if (cpu_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", cpu_rdy); end
        total++; if (dma_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", dma_busy); end
        for (int i = 0; i < 4; i++) begin
            cpu_ab = 16'h1230 + 16'(i * 7); cpu_do = 8'h50 + 8'(i); cpu_we = i[0];
            #1;
            total++;
            if (mem_ab !== cpu_ab || mem_we !== cpu_we || mem_do !== cpu_do || cpu_di !== mem_di) begin
                bad++;
                $display("FAIL idle_pass%0d got ab=%h we=%b do=%h want ab=%h we=%b do=%h",
                         i, mem_ab, mem_we, mem_do, cpu_ab, cpu_we, cpu_do);
            end
            tick();
            total++; if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin
                bad++; $display("FAIL idle_rdy%0d got rdy=%b busy=%b want 1/0", i, cpu_rdy, dma_busy);
            end
        end
        cpu_we = 1'b0;
    endtask

    task automatic test_no_trigger();
        cpu_ab = 16'h4015; cpu_do = 8'h03; cpu_we = 1'b1; #1;
        total++; if (mem_ab !== 16'h4015 || mem_we !== 1'b1 || mem_do !== 8'h03) begin
            bad++; $display("FAIL w4015_pass got ab=%h we=%b do=%h want 4015/1/03", mem_ab, mem_we, mem_do);
        end
        tick();
        cpu_ab = 16'h4014; cpu_we = 1'b0; #1;
        total++; if (mem_ab !== 16'h4014 || mem_we !== 1'b0) begin
            bad++; $display("FAIL r4014_pass got ab=%h we=%b want 4014/0", mem_ab, mem_we);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin
                bad++; $display("FAIL no_trig%0d got rdy=%b busy=%b want 1/0", i, cpu_rdy, dma_busy);
            end
            tick();
        end
    endtask

    // Trigger a DMA from an IDLE cycle whose parity is trig_par; inject>0
    // drives a stray trigger write at that stall cycle.
    task automatic run_dma(input string nm, input logic [7:0] page, input logic trig_par,
                           input int inject);
        int stall, nerr, nperr;
        int exp_stall;
        exp_stall = trig_par ? 514 : 513;
        wr_q.delete(); rd_q.delete(); rdpar_q.delete();
        cpu_we = 1'b0; cpu_ab = 16'h4014;
        while (tbpar !== trig_par) tick();
        cpu_do = page; cpu_we = 1'b1; #1;
        total++; if (mem_ab !== 16'h4014 || mem_we !== 1'b1 || mem_do !== page) begin
            bad++; $display("FAIL %s trig_pass got ab=%h we=%b do=%h", nm, mem_ab, mem_we, mem_do);
        end
        tick();
        cpu_we = 1'b0;
        total++; if (cpu_rdy !== 1'b0 || dma_busy !== 1'b1 || mem_we !== 1'b0 || mem_ab !== cpu_ab) begin
            bad++; $display("FAIL %s halt got rdy=%b busy=%b we=%b ab=%h want 0/1/0/4014",
                            nm, cpu_rdy, dma_busy, mem_we, mem_ab);
        end
        stall = 0;
        while (cpu_rdy !== 1'b1 && stall < 700) begin
            if (stall == inject) begin cpu_we = 1'b1; cpu_do = 8'h09; end
            else cpu_we = 1'b0;
            stall++; tick();
        end
        cpu_we = 1'b0;
        cpu_ab = 16'h0456; #1;
        total++; if (stall !== exp_stall) begin
            bad++; $display("FAIL %s stall got=%0d want=%0d", nm, stall, exp_stall);
        end
        total++; if (dma_busy !== 1'b0 || mem_ab !== 16'h0456) begin
            bad++; $display("FAIL %s first_idle got busy=%b ab=%h want 0/0456", nm, dma_busy, mem_ab);
        end
        total++; if (wr_q.size() != 256 || rd_q.size() != 256) begin
            bad++; $display("FAIL %s counts got wr=%0d rd=%0d want 256/256", nm, wr_q.size(), rd_q.size());
        end else begin
            nerr = 0; nperr = 0;
            for (int i = 0; i < 256; i++) begin
                if (wr_q[i] !== mem[{page, 8'(i)}] || rd_q[i] !== {page, 8'(i)}) begin
                    if (nerr == 0)
                        $display("FAIL %s byte%0d got rd=%h wr=%h want rd=%h wr=%h", nm, i,
                                 rd_q[i], wr_q[i], {page, 8'(i)}, mem[{page, 8'(i)}]);
                    nerr++;
                end
                if (rdpar_q[i] !== 1'b0) nperr++;
            end
            total++; if (nerr != 0) bad++;
            total++; if (nperr != 0) begin
                bad++; $display("FAIL %s read_parity got odd=%0d want=0", nm, nperr);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int n, guard;
        wr_q.delete();
        cpu_ab = 16'h4014; cpu_do = 8'h03; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        guard = 0;
        while (wr_q.size() < 100 && guard < 400) begin guard++; tick(); end
        total++; if (wr_q.size() < 100) begin
            bad++; $display("FAIL mid_progress got=%0d want>=100", wr_q.size());
        end
        reset = 1'b1; tick(); reset = 1'b0;
        cpu_ab = 16'h0789; cpu_we = 1'b1; cpu_do = 8'h11; #1;
        total++; if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || mem_we !== 1'b1 || mem_ab !== 16'h0789) begin
            bad++; $display("FAIL mid_reset got rdy=%b busy=%b we=%b ab=%h want 1/0/1/0789",
                            cpu_rdy, dma_busy, mem_we, mem_ab);
        end
        tick(); cpu_we = 1'b0;
        n = wr_q.size();
        repeat (600) tick();
        total++; if (wr_q.size() != n) begin
            bad++; $display("FAIL mid_no_writes got=%0d want=%0d", wr_q.size(), n);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
        for (int i = 0; i < 256; i++) begin
            mem[16'h0300 + 16'(i)] = 8'(i) ^ 8'hA5;
            mem[16'h0700 + 16'(i)] = 8'(i) ^ 8'h3C;
        end
        test_reset();
        test_no_trigger();
        run_dma("page3_align", 8'h03, 1'b1, -1);
        run_dma("page3_noalign", 8'h03, 1'b0, -1);
        test_reset_mid();
        run_dma("page7_after_reset", 8'h07, 1'b0, -1);
        run_dma("retrigger_ignored", 8'h03, 1'b1, 10);
        run_dma("page20_overlap", 8'h20, 1'b0, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_oam_dma.md
Name: cpu_oam_dma

Overview:
- Bus-master DMA stage between the 6502 core (cpu: clk, reset, AB, DI, DO, WE, RDY) and the system memory bus.
- A CPU write of page number P to TRIG_ADDR starts a transfer. The block stalls the core via RDY, then copies 256 bytes from P*256..P*256+255 to the fixed sprite-data port DST_ADDR.
- Outside a transfer it is a transparent pass-through of the CPU bus.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a DMA; the written byte is the source page.
- DST_ADDR, 16'h2004, destination address written once per transferred byte.
- XFER_LEN, 256, bytes per transfer; fixed to one page, index is 8 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_ab  in  16  CPU address (core AB)
- cpu_do  in  8  CPU write data (core DO)
- cpu_we  in  1  CPU write enable (core WE)
- cpu_di  out  8  read data to core DI; always equals mem_di
- cpu_rdy  out  1  to core RDY; low stalls the core
- mem_ab  out  16  memory bus address
- mem_do  out  8  memory bus write data
- mem_we  out  1  memory bus write enable
- mem_di  in  8  memory read data (combinational, same-cycle as mem_ab)
- dma_busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset; it is sampled only at the posedge of clk.
- Reset values: state=IDLE, idx=0, src_page=0, data_q=0, cyc_par=0, cpu_rdy=1, dma_busy=0.
- Reset mid-transfer: reset aborts a transfer immediately; no further DMA bus cycles occur.
- cyc_par: toggles every clock; it is 0 in the first cycle after reset.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - mem_ab=cpu_ab, mem_do=cpu_do, mem_we=cpu_we. The trigger write itself passes through to memory.
  - If cpu_we and cpu_ab==TRIG_ADDR at a posedge: latch src_page=cpu_do, idx=0, go to HALT.
- HALT: one cycle; cpu_rdy=0; bus idles with mem_we=0 and mem_ab=cpu_ab. Next state is READ if cyc_par==1 in HALT, else ALIGN.
- ALIGN: one cycle, same bus behaviour as HALT. It guarantees every READ falls on a cyc_par==0 cycle. Next state is READ.
- READ: mem_ab={src_page,idx}, mem_we=0; data_q<=mem_di at the posedge; go to WRITE.
- WRITE:
  - mem_ab=DST_ADDR, mem_do=data_q, mem_we=1.
  - If idx==255, go to IDLE; else idx<=idx+1 and go to READ.
  - idx is 8 bits and never wraps mid-transfer.
- cpu_rdy is 0 in HALT, ALIGN, READ and WRITE; it returns to 1 combinationally in the first IDLE cycle.
- In that first IDLE cycle mem_ab=cpu_ab again (the core's held address).
- Stall length, with trigger posedge at cycle T:
  - cpu_rdy is low from T+1 for exactly 513 cycles (no ALIGN) or 514 cycles (ALIGN).
  - 256 READ/WRITE pairs, no gaps.
- Triggers: no re-trigger is possible while busy, because the core is stalled. A write to TRIG_ADDR while not IDLE is ignored.
- Source page edge cases: src_page=8'h20 (source overlaps DST_ADDR page) needs no special handling; reads simply hit that page.
- cpu_di=mem_di in all states; the core ignores it while stalled.

Decomposition:
- Package cpu_bus_pkg holds:
  - dma_state_t enum (IDLE, HALT, ALIGN, READ, WRITE);
  - address constants OAM_DMA_TRIG=16'h4014 and OAM_DATA=16'h2004, used as parameter defaults;
  - typedef addr_t (16-bit) and byte_t (8-bit).
- The FSM and counters form a single module.
- The bus output mux (IDLE pass-through vs DMA drive) is small enough to stay inline. No sub-module is needed.

Test Plan:
- Reset held 2 cycles, then idle CPU bus → cpu_rdy=1, dma_busy=0, mem_ab tracks cpu_ab, mem_we tracks cpu_we each cycle.
- CPU writes 8'h03 to 16'h4014, with mem[0x0300+i]=i^8'hA5 → 256 writes to 16'h2004 with data (i^8'hA5) in order, from read addresses 0x0300..0x03FF. cpu_rdy low for 513 or 514 cycles, as cyc_par predicts.
- Parity check: trigger so that HALT has cyc_par=0 → exactly one ALIGN cycle, 514-cycle stall. Trigger one cycle later → no ALIGN, 513-cycle stall. Every READ has cyc_par==0.
- Assert reset at byte 100 of a transfer → next cycle cpu_rdy=1, dma_busy=0, mem_we=cpu_we. No further writes to 16'h2004. A subsequent trigger to page 8'h07 completes all 256 bytes.
- CPU writes to 16'h4015 and reads 16'h4014 → no DMA started, cpu_rdy stays 1, and the accesses pass through unchanged.
- Full system: cpu core + this block + 64K memory model. Program does LDA #$02 / STA $4014 / NOP; the core resumes at the NOP after the stall. The 256 sprite-port writes match page 2 contents.
